cpu_seq_ctrl: RTL and testbench
===============================

Name: cpu_seq_ctrl

Overview:
- Multicycle microsequencer for the 16-bit single-bus datapath.
- Drives regbank selects and write enable, memory write and bus enable, PC/IR/MAR/A/Z special-register load and tristate strobes, ALU op, and the flag-capture enable.
- Walks a fetch/decode/execute FSM per instruction; never enables two bus drivers in the same cycle.

Parameters:
- RESET_PC, 16'h0000, value the PC is loaded with during reset; exported as pc_resval.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  level; while 0 the FSM parks in IDLE at instruction boundaries
- ir  in  16  IR register value: [15:12] opcode, [11:9] rd, [8:6] rs, [5:0] unused
- status  in  4  flag-FF outputs {S,V,Z,C}
- rsel  out  3  regbank read select (regbank drives bus in T-states listed below)
- reg_t  out  1  regbank bus-drive qualifier
- wsel  out  3  regbank write select
- wrr  out  1  regbank write enable
- mem_write  out  1  memory write strobe
- mem_t  out  1  memory output onto bus
- pc_l, pc_t, pc_inc  out  1 each  PC load / drive / increment
- ir_l, mar_l, a_l  out  1 each  IR / MAR / ALU-A register load
- z_l, z_t  out  1 each  ALU result register load / drive
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 PASS-B
- sflag  out  1  flag capture enable
- pc_resval  out  16  equals RESET_PC
- halted  out  1  high in HALT
- illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Reset: state := IDLE. Every strobe output is 0; rsel, wsel and alu_op are 0; halted and illegal are 0. Reset wins over every other input in every state, including mid-instruction.
- IDLE:
  - run=1 -> F0; otherwise stay.
- F0: pc_t=1, mar_l=1 -> F1.
- F1: mem_t=1, ir_l=1, pc_inc=1 -> DEC.
- DEC: no bus driver. Branch on ir[15:12]:
  - 0 NOP -> F0/IDLE
  - 1-4 ALU (ADD, SUB, AND, OR) -> E0
  - 5 LD -> M0
  - 6 ST -> M0
  - 7 MOV -> E0
  - 8 JZ -> J0 if status[1]=1, else F0/IDLE
  - 9 JMP -> J0
  - F HALT -> HALT
  - others: illegal=1 for this cycle, treated as NOP.
  - "F0/IDLE" means F0 if run=1, else IDLE.
- E0: rsel=rd, reg_t=1, a_l=1 -> E1.
- E1: rsel=rs, reg_t=1, z_l=1.
  - alu_op = opcode-1 for opcodes 1-4; PASS-B for MOV.
  - sflag=1 for ALU opcodes only; 0 for MOV.
  - -> WB.
- WB: z_t=1, wsel=rd, wrr=1 -> F0/IDLE. Writing R[rd] completes at this edge.
- M0: rsel=rs, reg_t=1, mar_l=1 -> M1.
- M1:
  - LD: mem_t=1, wsel=rd, wrr=1.
  - ST: rsel=rd, reg_t=1, mem_write=1.
  - -> F0/IDLE.
- J0: rsel=rs, reg_t=1, pc_l=1 -> F0/IDLE.
- HALT: halted=1; stays until reset; run is ignored.
- All strobes are Moore outputs decoded from state and the registered ir. At most one of reg_t, mem_t, pc_t, z_t is high in any cycle.
- Cycle counts (IDLE excluded, run held 1):
  - NOP: 3
  - ALU/MOV: 6
  - LD/ST: 5
  - JMP, taken JZ: 4
  - untaken JZ: 3
- run deasserted mid-instruction: the instruction completes; the FSM then enters IDLE.
- rd == rs is legal. The E0/E1 ordering makes SUB compute R[rd]-R[rs].

Optional Feature:
- Macro SEQ_RETIRE_COUNT_EN.
- Defined:
  - Adds output retired[15:0], cleared by reset.
  - Increments by 1 on the cycle leaving WB, M1, J0, or DEC for NOP/untaken JZ/illegal.
  - HALT is not counted; wraps FFFF->0000.
- Undefined: port and logic absent; all other behaviour is identical.

Decomposition:
- Package cpu_seq_pkg holds:
  - opcode constants (OP_NOP..OP_HALT)
  - ALU op constants
  - state encoding constants (IDLE, F0, F1, DEC, E0, E1, WB, M0, M1, J0, HALT; 4-bit)
  - field bit positions
- One sub-module, seq_opdec: combinational opcode -> {class, alu_op, sets_flags, is_illegal}.

Test Plan:
- Reset, RESET_PC=16'h0010, run=1, ir=16'h0000 -> F0 on 2nd cycle after reset release; pc_t and mar_l are 1 in F0; the ir_l/pc_inc pulse follows.
- ir=16'h1A40 (ADD rd=5, rs=1) -> E0 rsel=5, E1 rsel=1, alu_op=0, sflag=1, WB wsel=5, wrr=1; total 6 cycles.
- ir=16'h6280 (ST rd=1, rs=2) -> M0 rsel=2 with mar_l; M1 rsel=1 with mem_write=1; wrr never asserted.
- ir=16'h8040 (JZ rs=1):
  - with status=4'b0010 -> J0 pc_l=1, rsel=1.
  - with status=4'b0000 -> back to F0 after DEC, no pc_l.
- ir=16'hB000 -> illegal pulses exactly 1 cycle in DEC, then F0. ir=16'hF000 -> halted=1; run toggling ignored; reset clears halted.
- Assert reset during E1 of an ADD -> next state IDLE, wrr never pulses. With SEQ_RETIRE_COUNT_EN: 3 ADDs -> retired=3.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the single-bus microsequencer: opcodes, ALU ops, FSM states, IR fields.
package cpu_seq_pkg;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS_LSB  = 6;
  localparam int unsigned FLAG_Z  = 1;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_PASSB = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_DEC  = 4'd3,
    S_E0   = 4'd4,
    S_E1   = 4'd5,
    S_WB   = 4'd6,
    S_M0   = 4'd7,
    S_M1   = 4'd8,
    S_J0   = 4'd9,
    S_HALT = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_ALU,
    CL_MOV,
    CL_LD,
    CL_ST,
    CL_JZ,
    CL_JMP,
    CL_HALT
  } op_class_t;

endpackage

// File: rtl/cpu_seq_ctrl_opdec.sv
// Combinational opcode classifier; undefined opcodes decode as NOP with is_illegal set.
module seq_opdec
  import cpu_seq_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_t  op_class,
  output logic [2:0] alu_op,
  output logic       sets_flags,
  output logic       is_illegal
);

  always_comb begin
    op_class   = CL_NOP;
    alu_op     = ALU_ADD;
    sets_flags = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_NOP: op_class = CL_NOP;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        op_class   = CL_ALU;
        alu_op     = opcode[2:0] - 3'd1;
        sets_flags = 1'b1;
      end
      OP_MOV: begin
        op_class = CL_MOV;
        alu_op   = ALU_PASSB;
      end
      OP_LD:   op_class = CL_LD;
      OP_ST:   op_class = CL_ST;
      OP_JZ:   op_class = CL_JZ;
      OP_JMP:  op_class = CL_JMP;
      OP_HALT: op_class = CL_HALT;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Fetch/decode/execute microsequencer for the 16-bit single-bus datapath.
// Optional SEQ_RETIRE_COUNT_EN adds a wrapping retired-instruction counter output.
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic [3:0]  status,
  output logic [2:0]  rsel,
  output logic        reg_t,
  output logic [2:0]  wsel,
  output logic        wrr,
  output logic        mem_write,
  output logic        mem_t,
  output logic        pc_l,
  output logic        pc_t,
  output logic        pc_inc,
  output logic        ir_l,
  output logic        mar_l,
  output logic        a_l,
  output logic        z_l,
  output logic        z_t,
  output logic [2:0]  alu_op,
  output logic        sflag,
  output logic [15:0] pc_resval,
  output logic        halted,
  output logic        illegal
`ifdef SEQ_RETIRE_COUNT_EN
  ,
  output logic [15:0] retired
`endif
);

  state_t     state;
  state_t     boundary;
  op_class_t  op_class;
  logic [2:0] dec_alu_op;
  logic       dec_sets_flags;
  logic       dec_illegal;
  logic [2:0] rd;
  logic [2:0] rs;
  logic       unused_bits;

  assign rd          = ir[RD_LSB +: 3];
  assign rs          = ir[RS_LSB +: 3];
  assign pc_resval   = RESET_PC;
  assign boundary    = run ? S_F0 : S_IDLE;
  assign unused_bits = ^{ir[5:0], status[3:2], status[0]};

  seq_opdec u_opdec (
    .opcode     (ir[OPC_LSB +: 4]),
    .op_class   (op_class),
    .alu_op     (dec_alu_op),
    .sets_flags (dec_sets_flags),
    .is_illegal (dec_illegal)
  );

`ifdef SEQ_RETIRE_COUNT_EN
  logic retire;
  always_comb begin
    retire = 1'b0;
    case (state)
      S_WB, S_M1, S_J0: retire = 1'b1;
      S_DEC: retire = (op_class == CL_NOP) ||
                      (op_class == CL_JZ && !status[FLAG_Z]);
      default: retire = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
`ifdef SEQ_RETIRE_COUNT_EN
      retired <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_F0;
        S_F0:   state <= S_F1;
        S_F1:   state <= S_DEC;
        S_DEC: begin
          case (op_class)
            CL_ALU, CL_MOV: state <= S_E0;
            CL_LD, CL_ST:   state <= S_M0;
            CL_JZ:          state <= status[FLAG_Z] ? S_J0 : boundary;
            CL_JMP:         state <= S_J0;
            CL_HALT:        state <= S_HALT;
            default:        state <= boundary;
          endcase
        end
        S_E0:             state <= S_E1;
        S_E1:             state <= S_WB;
        S_M0:             state <= S_M1;
        S_WB, S_M1, S_J0: state <= boundary;
        S_HALT:           state <= S_HALT;
        default:          state <= S_IDLE;
      endcase
`ifdef SEQ_RETIRE_COUNT_EN
      if (retire) retired <= retired + 16'd1;
`endif
    end
  end

  // Strobes are decoded from state and the live IR so DEC can flag an illegal opcode in-cycle.
  always_comb begin
    rsel      = '0;
    reg_t     = 1'b0;
    wsel      = '0;
    wrr       = 1'b0;
    mem_write = 1'b0;
    mem_t     = 1'b0;
    pc_l      = 1'b0;
    pc_t      = 1'b0;
    pc_inc    = 1'b0;
    ir_l      = 1'b0;
    mar_l     = 1'b0;
    a_l       = 1'b0;
    z_l       = 1'b0;
    z_t       = 1'b0;
    alu_op    = '0;
    sflag     = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_F0: begin
        pc_t  = 1'b1;
        mar_l = 1'b1;
      end
      S_F1: begin
        mem_t  = 1'b1;
        ir_l   = 1'b1;
        pc_inc = 1'b1;
      end
      S_DEC: illegal = dec_illegal;
      S_E0: begin
        rsel  = rd;
        reg_t = 1'b1;
        a_l   = 1'b1;
      end
      S_E1: begin
        rsel   = rs;
        reg_t  = 1'b1;
        z_l    = 1'b1;
        alu_op = dec_alu_op;
        sflag  = dec_sets_flags;
      end
      S_WB: begin
        z_t  = 1'b1;
        wsel = rd;
        wrr  = 1'b1;
      end
      S_M0: begin
        rsel  = rs;
        reg_t = 1'b1;
        mar_l = 1'b1;
      end
      S_M1: begin
        if (op_class == CL_ST) begin
          rsel      = rd;
          reg_t     = 1'b1;
          mem_write = 1'b1;
        end else begin
          mem_t = 1'b1;
          wsel  = rd;
          wrr   = 1'b1;
        end
      end
      S_J0: begin
        rsel  = rs;
        reg_t = 1'b1;
        pc_l  = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: stimulus queues per-cycle expected strobe sets, a negedge monitor checks them.
module tb_cpu_seq_ctrl;

  typedef struct packed {
    logic [2:0] rsel;
    logic       reg_t;
    logic [2:0] wsel;
    logic       wrr;
    logic       mem_write;
    logic       mem_t;
    logic       pc_l;
    logic       pc_t;
    logic       pc_inc;
    logic       ir_l;
    logic       mar_l;
    logic       a_l;
    logic       z_l;
    logic       z_t;
    logic [2:0] alu_op;
    logic       sflag;
    logic       halted;
    logic       illegal;
  } out_t;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [15:0] ir;
  logic [3:0]  status;
  logic [2:0]  rsel, wsel, alu_op;
  logic        reg_t, wrr, mem_write, mem_t, pc_l, pc_t, pc_inc;
  logic        ir_l, mar_l, a_l, z_l, z_t, sflag, halted, illegal;
  logic [15:0] pc_resval;
`ifdef SEQ_RETIRE_COUNT_EN
  logic [15:0] retired;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  out_t  sb_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  cpu_seq_ctrl #(.RESET_PC(16'h0010)) dut (
    .clk(clk), .reset(reset), .run(run), .ir(ir), .status(status),
    .rsel(rsel), .reg_t(reg_t), .wsel(wsel), .wrr(wrr),
    .mem_write(mem_write), .mem_t(mem_t),
    .pc_l(pc_l), .pc_t(pc_t), .pc_inc(pc_inc),
    .ir_l(ir_l), .mar_l(mar_l), .a_l(a_l), .z_l(z_l), .z_t(z_t),
    .alu_op(alu_op), .sflag(sflag), .pc_resval(pc_resval),
    .halted(halted), .illegal(illegal)
`ifdef SEQ_RETIRE_COUNT_EN
    , .retired(retired)
`endif
  );

  always @(negedge clk) begin
    out_t  e;
    out_t  a;
    string t;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      a = {rsel, reg_t, wsel, wrr, mem_write, mem_t, pc_l, pc_t, pc_inc,
           ir_l, mar_l, a_l, z_l, z_t, alu_op, sflag, halted, illegal};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", t, a, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input out_t e, input string t);
    sb_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] iv, input string t);
    out_t e;
    e = '0; e.pc_t = 1'b1; e.mar_l = 1'b1;
    cyc(e, {t, " F0"});
    e = '0; e.mem_t = 1'b1; e.ir_l = 1'b1; e.pc_inc = 1'b1;
    cyc(e, {t, " F1"});
    ir = iv;
  endtask

  task automatic dec(input logic ill, input string t);
    out_t e;
    e = '0; e.illegal = ill;
    cyc(e, {t, " DEC"});
  endtask

  task automatic alu_exec(input logic [2:0] rd, input logic [2:0] rs,
                          input logic [2:0] op, input logic sf, input string t);
    out_t e;
    e = '0; e.rsel = rd; e.reg_t = 1'b1; e.a_l = 1'b1;
    cyc(e, {t, " E0"});
    e = '0; e.rsel = rs; e.reg_t = 1'b1; e.z_l = 1'b1; e.alu_op = op; e.sflag = sf;
    cyc(e, {t, " E1"});
    e = '0; e.z_t = 1'b1; e.wsel = rd; e.wrr = 1'b1;
    cyc(e, {t, " WB"});
  endtask

  task automatic mem_exec(input logic [2:0] rd, input logic [2:0] rs,
                          input logic is_st, input string t);
    out_t e;
    e = '0; e.rsel = rs; e.reg_t = 1'b1; e.mar_l = 1'b1;
    cyc(e, {t, " M0"});
    e = '0;
    if (is_st) begin
      e.rsel = rd; e.reg_t = 1'b1; e.mem_write = 1'b1;
    end else begin
      e.mem_t = 1'b1; e.wsel = rd; e.wrr = 1'b1;
    end
    cyc(e, {t, " M1"});
  endtask

  task automatic jmp_exec(input logic [2:0] rs, input string t);
    out_t e;
    e = '0; e.rsel = rs; e.reg_t = 1'b1; e.pc_l = 1'b1;
    cyc(e, {t, " J0"});
  endtask

  logic [15:0] alu_ir [6] = '{16'h1A40, 16'h2A40, 16'h3A40, 16'h4A40, 16'h7A40, 16'h1240};
  logic [2:0]  alu_rd [6] = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd1};
  logic [2:0]  alu_exp[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
  logic        alu_sf [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    out_t h;
    reset = 1'b1; run = 1'b1; ir = 16'h0000; status = 4'b0000;
    @(posedge clk); #1;
    cyc('0, "reset held");
    reset = 1'b0;

    n_cmp++;
    if (pc_resval !== 16'h0010) begin
      n_bad++;
      $display("FAIL pc_resval: got %h want %h", pc_resval, 16'h0010);
    end

    cyc('0, "idle after release");
    fetch(16'h0000, "nop");
    dec(1'b0, "nop");

    for (int i = 0; i < 6; i++) begin
      fetch(alu_ir[i], "alu");
      dec(1'b0, "alu");
      alu_exec(alu_rd[i], 3'd1, alu_exp[i], alu_sf[i], "alu");
    end

    fetch(16'h6280, "st");
    dec(1'b0, "st");
    mem_exec(3'd1, 3'd2, 1'b1, "st");

    fetch(16'h5280, "ld");
    dec(1'b0, "ld");
    mem_exec(3'd1, 3'd2, 1'b0, "ld");

    status = 4'b0010;
    fetch(16'h8040, "jz taken");
    dec(1'b0, "jz taken");
    jmp_exec(3'd1, "jz taken");

    status = 4'b1101;
    fetch(16'h8040, "jz untaken");
    dec(1'b0, "jz untaken");

    status = 4'b0000;
    fetch(16'h9040, "jmp");
    dec(1'b0, "jmp");
    jmp_exec(3'd1, "jmp");

    fetch(16'hB000, "illegal");
    dec(1'b1, "illegal");

    fetch(16'h1A40, "run drop");
    dec(1'b0, "run drop");
    run = 1'b0;
    alu_exec(3'd5, 3'd1, 3'd0, 1'b1, "run drop");
    cyc('0, "run drop idle1");
    run = 1'b1;
    cyc('0, "run drop idle2");

    fetch(16'h1A40, "mid reset");
    dec(1'b0, "mid reset");
    h = '0; h.rsel = 3'd5; h.reg_t = 1'b1; h.a_l = 1'b1;
    cyc(h, "mid reset E0");
    reset = 1'b1;
    h = '0; h.rsel = 3'd1; h.reg_t = 1'b1; h.z_l = 1'b1; h.sflag = 1'b1;
    cyc(h, "mid reset E1");
    reset = 1'b0;
    cyc('0, "mid reset idle");

    fetch(16'hF000, "halt");
    dec(1'b0, "halt");
    h = '0; h.halted = 1'b1;
    cyc(h, "halt 1");
    run = 1'b0;
    cyc(h, "halt 2");
    run = 1'b1;
    cyc(h, "halt 3");
    reset = 1'b1;
    cyc(h, "halt reset cycle");
    reset = 1'b0;
    cyc('0, "halt cleared");

    for (int i = 0; i < 3; i++) begin
      fetch(16'h1A40, "retire add");
      dec(1'b0, "retire add");
      alu_exec(3'd5, 3'd1, 3'd0, 1'b1, "retire add");
    end
`ifdef SEQ_RETIRE_COUNT_EN
    n_cmp++;
    if (retired !== 16'd3) begin
      n_bad++;
      $display("FAIL retired: got %0d want %0d", retired, 3);
    end
`endif
    fetch(16'h0000, "tail nop");

    @(negedge clk); #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: got %0d left want %0d", sb_q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
